// File: rtl/cnnacc_pkg.sv
// rtl/cnnacc_pkg.sv - shared defaults and types for the feature-map buffer
// Purpose: default geometry of the feature-map ping-pong buffer and the
//          bank-index type that matches those defaults.
package cnnacc_pkg;

  localparam int FMAP_DATA_W = 64;
  localparam int FMAP_DEPTH  = 4096;
  localparam int FMAP_BANKS  = 2;
  localparam int FMAP_BANK_W = $clog2(FMAP_BANKS);

  typedef logic [FMAP_BANK_W-1:0] fmap_bank_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, registered read-first read port
// Purpose: one bank of feature-map storage.
// Ports:
//   clk, rst      clock, synchronous active-low reset (read register only)
//   we/waddr/wdata write port
//   re/raddr      read request; rdata is registered and holds when re=0
module sdp_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem gives read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fmap_pingpong_buf.sv
// rtl/fmap_pingpong_buf.sv - N-bank feature-map ping-pong buffer
// Purpose: producer fills one bank while the consumer drains another; bank
//          ownership passes through per-bank full flags.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_done    producer side; wr_ready, wr_bank status
//   rd_en/rd_addr/rd_done            consumer side; rd_ready, rd_bank status
//   rd_data/rd_valid                 registered read return (1 cycle)
//   full_cnt                         number of full banks
//   err_ovf                          sticky protocol error
module fmap_pingpong_buf
  import cnnacc_pkg::*;
#(
  parameter int DATA_W    = FMAP_DATA_W,
  parameter int DEPTH     = FMAP_DEPTH,
  parameter int NUM_BANKS = FMAP_BANKS,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  output logic [BANK_W-1:0] wr_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_done,
  output logic              rd_ready,
  output logic [BANK_W-1:0] rd_bank,
  output logic [BANK_W:0]   full_cnt,
  output logic              err_ovf
);

  logic [NUM_BANKS-1:0] full;
  logic [NUM_BANKS-1:0] full_nxt;
  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  logic [BANK_W-1:0]    rd_sel;
  logic [DATA_W-1:0]    ram_q [NUM_BANKS];
  logic                 wr_done_ok;
  logic                 rd_done_ok;
  logic                 ovf_evt;

  // Explicit wrap so a 3-bank ring does not run through index 3.
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  always_comb begin
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    full_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (wr_bank == BANK_W'(i)) wr_ready = !full[i];
      if (rd_bank == BANK_W'(i)) rd_ready = full[i];
      full_cnt = full_cnt + (BANK_W + 1)'(full[i]);
    end
  end

  // When both dones target the same bank only one of them can be legal, so
  // the generic ready gating already resolves that case.
  assign wr_done_ok = wr_done && wr_ready;
  assign rd_done_ok = rd_done && rd_ready;
  assign ovf_evt    = (wr_en && !wr_ready) || (wr_done && !wr_ready) ||
                      (rd_done && !rd_ready);

  always_comb begin
    full_nxt = full;
    bank_we  = '0;
    bank_re  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (wr_done_ok && wr_bank == BANK_W'(i)) full_nxt[i] = 1'b1;
      if (rd_done_ok && rd_bank == BANK_W'(i)) full_nxt[i] = 1'b0;
      bank_we[i] = wr_en && wr_ready && (wr_bank == BANK_W'(i));
      bank_re[i] = rd_en && rd_ready && (rd_bank == BANK_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full     <= '0;
      wr_bank  <= '0;
      rd_bank  <= '0;
      rd_sel   <= '0;
      rd_valid <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      full     <= full_nxt;
      rd_valid <= rd_en && rd_ready;
      if (wr_done_ok) wr_bank <= next_bank(wr_bank);
      if (rd_done_ok) rd_bank <= next_bank(rd_bank);
      // Capture the bank being read so a same-cycle rd_done still returns
      // data from the old bank.
      if (rd_en && rd_ready) rd_sel <= rd_bank;
      if (ovf_evt) err_ovf <= 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      sdp_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
      ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we[g]),
        .waddr(wr_addr),
        .wdata(wr_data),
        .re   (bank_re[g]),
        .raddr(rd_addr),
        .rdata(ram_q[g])
      );
    end
  endgenerate

  // Bank output registers and rd_sel only change on a read, so rd_data
  // holds between reads.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel == BANK_W'(i)) rd_data = ram_q[i];
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// tb/tb_fmap_pingpong_buf.sv - directed self-checking bench for fmap_pingpong_buf
module tb_fmap_pingpong_buf;

  localparam int DW = 64;
  localparam int DP = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a: two banks
  logic          a_rst, a_wr_en, a_wr_done, a_rd_en, a_rd_done;
  logic [AW-1:0] a_wr_addr, a_rd_addr;
  logic [DW-1:0] a_wr_data, a_rd_data;
  logic          a_wr_ready, a_rd_ready, a_rd_valid, a_err;
  logic [0:0]    a_wr_bank, a_rd_bank;
  logic [1:0]    a_full_cnt;

  // DUT b: three banks
  logic          b_rst, b_wr_en, b_wr_done, b_rd_en, b_rd_done;
  logic [AW-1:0] b_wr_addr, b_rd_addr;
  logic [DW-1:0] b_wr_data, b_rd_data;
  logic          b_wr_ready, b_rd_ready, b_rd_valid, b_err;
  logic [1:0]    b_wr_bank, b_rd_bank;
  logic [2:0]    b_full_cnt;

  fmap_pingpong_buf #(.DATA_W(DW), .DEPTH(DP), .NUM_BANKS(2)) u_a (
    .clk(clk), .rst(a_rst),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_done(a_wr_done),
    .wr_ready(a_wr_ready), .wr_bank(a_wr_bank),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .rd_done(a_rd_done), .rd_ready(a_rd_ready), .rd_bank(a_rd_bank),
    .full_cnt(a_full_cnt), .err_ovf(a_err)
  );

  fmap_pingpong_buf #(.DATA_W(DW), .DEPTH(DP), .NUM_BANKS(3)) u_b (
    .clk(clk), .rst(b_rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_done(b_wr_done),
    .wr_ready(b_wr_ready), .wr_bank(b_wr_bank),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .rd_done(b_rd_done), .rd_ready(b_rd_ready), .rd_bank(b_rd_bank),
    .full_cnt(b_full_cnt), .err_ovf(b_err)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en = 0; a_wr_done = 0; a_rd_en = 0; a_rd_done = 0;
    a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
  endtask

  task automatic b_idle();
    b_wr_en = 0; b_wr_done = 0; b_rd_en = 0; b_rd_done = 0;
    b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
  endtask

  task automatic test_reset();
    a_idle(); b_idle();
    a_rst = 0; b_rst = 0;
    tick();
    a_rst = 1; b_rst = 1;
    tick();
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_a_wr_ready got %0b exp 1", a_wr_ready); end
    checks++; if (a_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_a_rd_ready got %0b exp 0", a_rd_ready); end
    checks++; if (a_full_cnt !== 2'd0) begin errors++; $display("FAIL reset_a_full_cnt got %0d exp 0", a_full_cnt); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_err got %0b exp 0", a_err); end
    checks++; if (a_wr_bank !== 1'd0 || a_rd_bank !== 1'd0) begin errors++; $display("FAIL reset_a_banks got wr %0d rd %0d exp 0 0", a_wr_bank, a_rd_bank); end
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 64'd0) begin errors++; $display("FAIL reset_a_rd got valid %0b data %0h exp 0 0", a_rd_valid, a_rd_data); end
    checks++; if (b_wr_ready !== 1'b1 || b_rd_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got wr %0b rd %0b exp 1 0", b_wr_ready, b_rd_ready); end
    checks++; if (b_full_cnt !== 3'd0 || b_err !== 1'b0) begin errors++; $display("FAIL reset_b_cnt_err got cnt %0d err %0b exp 0 0", b_full_cnt, b_err); end
    checks++; if (b_wr_bank !== 2'd0 || b_rd_bank !== 2'd0) begin errors++; $display("FAIL reset_b_banks got wr %0d rd %0d exp 0 0", b_wr_bank, b_rd_bank); end
  endtask

  task automatic test_two_bank_roundtrip();
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_addr = AW'(i); a_wr_data = 64'hA0 + 64'(i);
      tick();
    end
    a_idle();
    a_wr_done = 1;
    tick();
    a_idle();
    checks++; if (a_rd_ready !== 1'b1) begin errors++; $display("FAIL rt_rd_ready got %0b exp 1", a_rd_ready); end
    checks++; if (a_wr_bank !== 1'd1 || a_wr_ready !== 1'b1) begin errors++; $display("FAIL rt_wr_bank got bank %0d ready %0b exp 1 1", a_wr_bank, a_wr_ready); end
    checks++; if (a_full_cnt !== 2'd1) begin errors++; $display("FAIL rt_full_cnt got %0d exp 1", a_full_cnt); end
    a_rd_en = 1; a_rd_addr = 4'd2;
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL rt_valid_before got %0b exp 0", a_rd_valid); end
    tick();
    a_idle();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'hA2) begin errors++; $display("FAIL rt_read got valid %0b data %0h exp 1 a2", a_rd_valid, a_rd_data); end
    tick();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 64'hA2) begin errors++; $display("FAIL rt_hold got valid %0b data %0h exp 0 a2", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_back_to_back();
    // bank 0 full, wr_bank=1, rd_bank=0: put one word in bank 1
    a_wr_en = 1; a_wr_addr = 4'd0; a_wr_data = 64'hB0;
    tick();
    a_idle();
    a_wr_done = 1; a_rd_done = 1; a_rd_en = 1; a_rd_addr = 4'd3;
    tick();
    a_idle();
    checks++; if (a_full_cnt !== 2'd1) begin errors++; $display("FAIL b2b_full_cnt got %0d exp 1", a_full_cnt); end
    checks++; if (a_wr_bank !== 1'd0 || a_rd_bank !== 1'd1) begin errors++; $display("FAIL b2b_banks got wr %0d rd %0d exp 0 1", a_wr_bank, a_rd_bank); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %0b exp 0", a_err); end
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'hA3) begin errors++; $display("FAIL b2b_old_bank_read got valid %0b data %0h exp 1 a3", a_rd_valid, a_rd_data); end
    a_rd_en = 1; a_rd_addr = 4'd0;
    tick();
    a_idle();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'hB0) begin errors++; $display("FAIL b2b_bank1_read got valid %0b data %0h exp 1 b0", a_rd_valid, a_rd_data); end
  endtask

  task automatic test_rd_done_underflow();
    a_rd_done = 1;
    tick();
    a_idle();
    checks++; if (a_full_cnt !== 2'd0 || a_rd_bank !== 1'd0 || a_rd_ready !== 1'b0) begin errors++; $display("FAIL uf_release got cnt %0d rd %0d ready %0b exp 0 0 0", a_full_cnt, a_rd_bank, a_rd_ready); end
    a_rd_en = 1; a_rd_addr = 4'd1;
    tick();
    a_idle();
    checks++; if (a_rd_valid !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL uf_rd_en_empty got valid %0b err %0b exp 0 0", a_rd_valid, a_err); end
    a_rd_done = 1;
    tick();
    a_idle();
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL uf_err got %0b exp 1", a_err); end
    checks++; if (a_rd_bank !== 1'd0 || a_wr_bank !== 1'd0 || a_full_cnt !== 2'd0) begin errors++; $display("FAIL uf_no_move got rd %0d wr %0d cnt %0d exp 0 0 0", a_rd_bank, a_wr_bank, a_full_cnt); end
    tick();
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %0b exp 1", a_err); end
  endtask

  task automatic test_three_banks();
    for (int k = 0; k < 3; k++) begin
      b_wr_en = 1; b_wr_done = 1; b_wr_addr = 4'd0; b_wr_data = 64'hC0 + 64'(k);
      tick();
    end
    b_idle();
    checks++; if (b_full_cnt !== 3'd3 || b_wr_ready !== 1'b0) begin errors++; $display("FAIL tb_full got cnt %0d wr_ready %0b exp 3 0", b_full_cnt, b_wr_ready); end
    checks++; if (b_wr_bank !== 2'd0 || b_rd_ready !== 1'b1 || b_err !== 1'b0) begin errors++; $display("FAIL tb_wrap got wr %0d rd_ready %0b err %0b exp 0 1 0", b_wr_bank, b_rd_ready, b_err); end
    b_wr_en = 1; b_wr_addr = 4'd0; b_wr_data = 64'hFF;
    tick();
    b_idle();
    checks++; if (b_err !== 1'b1) begin errors++; $display("FAIL tb_ovf got %0b exp 1", b_err); end
    b_rd_en = 1; b_rd_addr = 4'd0;
    tick();
    b_idle();
    checks++; if (b_rd_data !== 64'hC0) begin errors++; $display("FAIL tb_dropped_write got %0h exp c0", b_rd_data); end
    b_rd_done = 1;
    tick();
    b_idle();
    checks++; if (b_full_cnt !== 3'd2 || b_wr_ready !== 1'b1 || b_rd_bank !== 2'd1) begin errors++; $display("FAIL tb_release got cnt %0d wr_ready %0b rd %0d exp 2 1 1", b_full_cnt, b_wr_ready, b_rd_bank); end
    b_rd_en = 1; b_rd_addr = 4'd0; b_rd_done = 1;
    tick();
    b_idle();
    checks++; if (b_rd_data !== 64'hC1 || b_rd_bank !== 2'd2) begin errors++; $display("FAIL tb_bank1 got data %0h rd %0d exp c1 2", b_rd_data, b_rd_bank); end
    b_rd_en = 1; b_rd_addr = 4'd0; b_rd_done = 1;
    tick();
    b_idle();
    checks++; if (b_rd_data !== 64'hC2 || b_rd_bank !== 2'd0 || b_full_cnt !== 3'd0) begin errors++; $display("FAIL tb_rd_wrap got data %0h rd %0d cnt %0d exp c2 0 0", b_rd_data, b_rd_bank, b_full_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    a_rst = 0;
    tick();
    a_rst = 1;
    a_wr_en = 1; a_wr_done = 1; a_wr_addr = 4'd1; a_wr_data = 64'h11;
    tick();
    a_idle();
    a_wr_en = 1; a_wr_addr = 4'd2; a_wr_data = 64'h22;
    checks++; if (a_full_cnt !== 2'd1 || a_err !== 1'b0) begin errors++; $display("FAIL rm_pre got cnt %0d err %0b exp 1 0", a_full_cnt, a_err); end
    // reset lands together with an active write and an active read
    a_rd_en = 1; a_rd_addr = 4'd1; a_rst = 0;
    tick();
    a_rst = 1;
    a_idle();
    checks++; if (a_full_cnt !== 2'd0 || a_wr_bank !== 1'd0 || a_rd_bank !== 1'd0) begin errors++; $display("FAIL rm_state got cnt %0d wr %0d rd %0d exp 0 0 0", a_full_cnt, a_wr_bank, a_rd_bank); end
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 64'd0 || a_wr_ready !== 1'b1) begin errors++; $display("FAIL rm_out got valid %0b data %0h wr_ready %0b exp 0 0 1", a_rd_valid, a_rd_data, a_wr_ready); end
    a_wr_en = 1; a_wr_addr = 4'd5; a_wr_data = 64'h55AA;
    tick();
    a_idle();
    a_wr_done = 1;
    tick();
    a_idle();
    a_rd_en = 1; a_rd_addr = 4'd5;
    tick();
    a_idle();
    checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 64'h55AA) begin errors++; $display("FAIL rm_roundtrip got valid %0b data %0h exp 1 55aa", a_rd_valid, a_rd_data); end
  endtask

  initial begin
    a_rst = 1; b_rst = 1;
    a_idle(); b_idle();
    test_reset();
    test_two_bank_roundtrip();
    test_back_to_back();
    test_rd_done_underflow();
    test_three_banks();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
